uart_line_packetizer: RTL and testbench
=======================================

Name: uart_line_packetizer

Overview:
- Sits between the pixel buffer read side and the RS232C transmitter (rsio_01a) in the rs_clk domain.
- Consumes the captured pixel byte stream and wraps each image line in a framed packet: sync, line index, payload, checksum.
- Paces bytes to the UART with a start/busy handshake.
- Lets the host resynchronise on lines and detect corrupted transfers.

Parameters:
- LINE_BYTES, 1280, payload bytes per packet (one line; 640 px × 2 B YUV). Legal range 1..65535.
- SYNC0, 8'hAA, first sync byte.
- SYNC1, 8'h55, second sync byte.
- GUARD, 4, cycles after tx_start during which tx_busy is ignored (covers UART start latency). Must be ≥ 1.

Ports:
- rs_clk  in  1  clock (UART clock domain)
- rs_reset  in  1  asynchronous reset, active high
- in_valid  in  1  upstream byte valid
- in_data  in  8  upstream pixel byte
- in_sof  in  1  qualifies in_data as first byte of a frame
- in_eol  in  1  qualifies in_data as last byte of a line
- in_ready  out  1  block accepts in_data this cycle (in_valid & in_ready)
- tx_start  out  1  one-cycle pulse; UART latches tx_data
- tx_data  out  8  byte to transmit, held stable from tx_start until the next tx_start
- tx_busy  in  1  UART transmitting (1 = busy)
- line_idx  out  16  index of the packet currently being sent
- err  out  1  sticky framing error; cleared only by reset

Behaviour:
- Reset (async assert, sync release): state IDLE; tx_start=0, tx_data=0, in_ready=0, line_idx=0, err=0, byte count=0, checksum=0.
- Packet bytes in order: SYNC0, SYNC1, line_idx[15:8], line_idx[7:0], LINE_BYTES payload bytes, CSUM.
  - CSUM = 8-bit modulo-256 sum of the payload bytes.
- Byte send handshake (same for every byte):
  - Wait while tx_busy=1.
  - Then drive tx_data and pulse tx_start for exactly 1 cycle.
  - Ignore tx_busy for the next GUARD cycles, then wait for tx_busy=0 before the next byte.
  - At least GUARD+1 cycles between consecutive tx_start pulses.
- State machine: IDLE -> HDR0 -> HDR1 -> IDXH -> IDXL -> PAY -> CSUM -> IDLE.
  - IDLE: in_ready=0. Move to HDR0 when in_valid=1. No byte is consumed in IDLE.
  - Line index latch: at the IDLE->HDR0 transition, if in_sof=1 on the pending byte, line_idx becomes 0 before IDXH/IDXL are sent.
  - PAY: in_ready=1 only in the cycle the send handshake is ready to issue tx_start.
    - An accepted byte is sent in that same cycle (tx_data=in_data) and added to the checksum.
    - No skid; in_ready is combinationally gated by handshake readiness.
  - CSUM: send the checksum. Then line_idx += 1 (16-bit, wraps 65535->0) and the byte count and checksum clear. Return to IDLE.
- Boundary conditions:
  - Short line (in_eol accepted with count < LINE_BYTES): in_ready drops; the remaining payload is padded with 8'h00 (included in the checksum); err=1.
  - Long line (LINE_BYTES-th byte accepted with in_eol=0): packet closes normally; err=1. The next byte starts a new packet.
  - in_sof on a non-first payload byte: err=1; byte sent as normal; line_idx not reset until the next packet start.
  - in_eol on exactly the LINE_BYTES-th byte: normal, err unchanged.
  - tx_busy stuck high: block waits indefinitely, with no timeout.
  - Reset mid-packet: the packet is abandoned and tx_start is deasserted immediately. The host discards it by its missing checksum.
- Latency: first tx_start no earlier than 1 cycle after in_valid rises in IDLE with tx_busy=0.

Test Plan:
- LINE_BYTES=4, GUARD=2. Bytes 01,02,03,04 with sof on 01 and eol on 04; UART model busy for 10 cycles per byte. Required sequence: AA 55 00 00 01 02 03 04 0A. err=0, line_idx=1 afterwards.
- Three consecutive lines, sof only on the first: line index bytes 0000, 0001, 0002. A fourth line with sof restarts at 0000.
- Short line (LINE_BYTES=4): 10,20 with eol on 20. Required: AA 55 idx idx 10 20 00 00 30; err=1; next packet still well formed.
- Long line (LINE_BYTES=4): 6 bytes 01..06, no eol. Required: packet 01..04 with CSUM 0A, then a new packet starting with 05,06; err=1.
- Timing check: tx_busy held low permanently, GUARD=4. tx_start pulses are spaced exactly 5 cycles. tx_data is stable between pulses. in_valid=1 with in_ready=0 never consumes a byte (compare against a scoreboard).
- Async reset asserted during the payload: tx_start=0 and in_ready=0 immediately; all outputs at reset values. After release, a new packet starts from AA with line_idx=0.

Source files
------------

// File: rtl/uart_line_packetizer.sv
// Frames each pixel line as SYNC0 SYNC1 IDXH IDXL payload CSUM and paces the
// bytes into an RS232C transmitter with a start/busy handshake.
module uart_line_packetizer #(
    parameter int unsigned LINE_BYTES = 1280,
    parameter logic [7:0]  SYNC0      = 8'hAA,
    parameter logic [7:0]  SYNC1      = 8'h55,
    parameter int unsigned GUARD      = 4
) (
    input  logic        rs_clk,
    input  logic        rs_reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_sof,
    input  logic        in_eol,
    output logic        in_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic [15:0] line_idx,
    output logic        err
);

    localparam int unsigned GW   = $clog2(GUARD + 1);
    localparam logic [15:0] LAST = 16'(LINE_BYTES - 1);

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, IDXH, IDXL, PAY, CSUM} state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  guard_q;
    logic [15:0]    cnt_q;
    logic [7:0]     csum_q;
    logic           pad_q;

    logic           send_rdy_c;
    logic           fire_c;
    logic           accept_c;
    logic [7:0]     byte_c;

    // Busy is masked while the guard counter runs down after each start pulse.
    assign send_rdy_c = (guard_q == '0) && !tx_busy;

    always_ff @(posedge rs_clk or posedge rs_reset) begin
        if (rs_reset) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        fire_c   = 1'b0;
        accept_c = 1'b0;
        byte_c   = 8'h00;
        case (state_q)
            IDLE: if (in_valid) state_d = HDR0;
            HDR0: if (send_rdy_c) begin
                fire_c  = 1'b1;
                byte_c  = SYNC0;
                state_d = HDR1;
            end
            HDR1: if (send_rdy_c) begin
                fire_c  = 1'b1;
                byte_c  = SYNC1;
                state_d = IDXH;
            end
            IDXH: if (send_rdy_c) begin
                fire_c  = 1'b1;
                byte_c  = line_idx[15:8];
                state_d = IDXL;
            end
            IDXL: if (send_rdy_c) begin
                fire_c  = 1'b1;
                byte_c  = line_idx[7:0];
                state_d = PAY;
            end
            PAY: begin
                // After a short line the remainder is zero-filled without upstream.
                if (pad_q) begin
                    if (send_rdy_c) begin
                        fire_c = 1'b1;
                        if (cnt_q == LAST) state_d = CSUM;
                    end
                end else begin
                    in_ready = send_rdy_c;
                    if (send_rdy_c && in_valid) begin
                        fire_c   = 1'b1;
                        accept_c = 1'b1;
                        byte_c   = in_data;
                        if (cnt_q == LAST) state_d = CSUM;
                    end
                end
            end
            CSUM: if (send_rdy_c) begin
                fire_c  = 1'b1;
                byte_c  = csum_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rs_clk or posedge rs_reset) begin
        if (rs_reset) begin
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            guard_q  <= '0;
            line_idx <= 16'h0000;
            err      <= 1'b0;
            cnt_q    <= 16'h0000;
            csum_q   <= 8'h00;
            pad_q    <= 1'b0;
        end else begin
            tx_start <= fire_c;
            if (fire_c) begin
                tx_data <= byte_c;
                guard_q <= GW'(GUARD);
            end else if (guard_q != '0) begin
                guard_q <= guard_q - GW'(1);
            end

            if (state_q == IDLE && in_valid && in_sof) line_idx <= 16'h0000;

            if (state_q == PAY && fire_c) begin
                csum_q <= csum_q + byte_c;
                cnt_q  <= cnt_q + 16'd1;
            end

            // Framing checks on bytes actually taken from upstream.
            if (accept_c) begin
                if (in_eol && cnt_q != LAST) begin
                    pad_q <= 1'b1;
                    err   <= 1'b1;
                end
                if (!in_eol && cnt_q == LAST) err <= 1'b1;
                if (in_sof && cnt_q != 16'h0000) err <= 1'b1;
            end

            if (state_q == CSUM && fire_c) begin
                line_idx <= line_idx + 16'd1;
                cnt_q    <= 16'h0000;
                csum_q   <= 8'h00;
                pad_q    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_line_packetizer.sv
// Directed bench: instance a (GUARD=2, busy UART model) for framing/boundary
// cases, instance b (GUARD=4, never busy) for pulse spacing and consumption.
module tb_uart_line_packetizer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;

    logic        a_in_valid = 1'b0, a_in_sof = 1'b0, a_in_eol = 1'b0, a_tx_busy = 1'b0;
    logic [7:0]  a_in_data = 8'h00;
    logic        a_in_ready, a_tx_start, a_err;
    logic [7:0]  a_tx_data;
    logic [15:0] a_line_idx;

    logic        b_in_valid = 1'b0, b_in_sof = 1'b0, b_in_eol = 1'b0, b_tx_busy = 1'b0;
    logic [7:0]  b_in_data = 8'h00;
    logic        b_in_ready, b_tx_start, b_err;
    logic [7:0]  b_tx_data;
    logic [15:0] b_line_idx;

    uart_line_packetizer #(.LINE_BYTES(4), .GUARD(2)) dut_a (
        .rs_clk(clk), .rs_reset(rst),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_sof(a_in_sof), .in_eol(a_in_eol),
        .in_ready(a_in_ready), .tx_start(a_tx_start), .tx_data(a_tx_data),
        .tx_busy(a_tx_busy), .line_idx(a_line_idx), .err(a_err)
    );

    uart_line_packetizer #(.LINE_BYTES(4), .GUARD(4)) dut_b (
        .rs_clk(clk), .rs_reset(rst),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_sof(b_in_sof), .in_eol(b_in_eol),
        .in_ready(b_in_ready), .tx_start(b_tx_start), .tx_data(b_tx_data),
        .tx_busy(b_tx_busy), .line_idx(b_line_idx), .err(b_err)
    );

    int checks = 0;
    int errors = 0;
    int pkt_no = 0;
    logic [7:0] q[$];
    int busy_cnt = 0;

    // UART model for instance a: latches a byte per start pulse, busy 10 cycles.
    always begin
        @(posedge clk);
        #1;
        if (rst) busy_cnt = 0;
        else if (a_tx_start) begin
            q.push_back(a_tx_data);
            busy_cnt = 10;
        end else if (busy_cnt > 0) busy_cnt--;
        a_tx_busy = (busy_cnt != 0);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic [7:0] d, input logic s, input logic e);
        int n = 0;
        bit ok = 0;
        @(negedge clk);
        a_in_valid = 1'b1; a_in_data = d; a_in_sof = s; a_in_eol = e;
        while (!ok && n < 2000) begin
            if (a_in_ready) begin
                @(posedge clk);
                ok = 1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        if (!ok) chk("drive_timeout", 16'd0, 16'd1);
    endtask

    task automatic idle_a();
        @(negedge clk);
        a_in_valid = 1'b0; a_in_sof = 1'b0; a_in_eol = 1'b0;
    endtask

    task automatic check_pkt(input logic [15:0] idx, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] cs);
        logic [7:0]  exp [9];
        logic [15:0] obs;
        int k = 0;
        exp = '{8'hAA, 8'h55, idx[15:8], idx[7:0], b0, b1, b2, b3, cs};
        while (q.size() < 9 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (q.size() < 9) chk($sformatf("pkt%0d_timeout", pkt_no), 16'(q.size()), 16'd9);
        for (int i = 0; i < 9; i++) begin
            if (q.size() == 0) obs = 16'hxxxx;
            else               obs = {8'h00, q.pop_front()};
            chk($sformatf("pkt%0d_byte%0d", pkt_no, i), obs, {8'h00, exp[i]});
        end
        pkt_no++;
    endtask

    initial begin
        logic [7:0] exp_b [9];
        int cyc, last_cyc, npulse, bidx, stab_err;
        logic [7:0] last_data;

        repeat (3) @(negedge clk);
        chk("rst_tx_start", 16'(a_tx_start), 16'd0);
        chk("rst_tx_data",  16'(a_tx_data),  16'd0);
        chk("rst_in_ready", 16'(a_in_ready), 16'd0);
        chk("rst_line_idx", a_line_idx,      16'd0);
        chk("rst_err",      16'(a_err),      16'd0);
        rst = 1'b0;

        // Nominal line, then two lines without sof, then sof restarts the index.
        drive_a(8'h01, 1, 0); drive_a(8'h02, 0, 0); drive_a(8'h03, 0, 0); drive_a(8'h04, 0, 1); idle_a();
        check_pkt(16'h0000, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
        chk("nom_err", 16'(a_err), 16'd0);
        chk("nom_line_idx", a_line_idx, 16'd1);
        drive_a(8'h11, 0, 0); drive_a(8'h22, 0, 0); drive_a(8'h33, 0, 0); drive_a(8'h44, 0, 1); idle_a();
        check_pkt(16'h0001, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA);
        drive_a(8'hFF, 0, 0); drive_a(8'h01, 0, 0); drive_a(8'h80, 0, 0); drive_a(8'h80, 0, 1); idle_a();
        check_pkt(16'h0002, 8'hFF, 8'h01, 8'h80, 8'h80, 8'h00);
        drive_a(8'h05, 1, 0); drive_a(8'h06, 0, 0); drive_a(8'h07, 0, 0); drive_a(8'h08, 0, 1); idle_a();
        check_pkt(16'h0000, 8'h05, 8'h06, 8'h07, 8'h08, 8'h1A);
        chk("three_err", 16'(a_err), 16'd0);

        // Short line: zero padding, err set, following packet still framed.
        drive_a(8'h10, 0, 0); drive_a(8'h20, 0, 1); idle_a();
        check_pkt(16'h0001, 8'h10, 8'h20, 8'h00, 8'h00, 8'h30);
        chk("short_err", 16'(a_err), 16'd1);
        drive_a(8'h01, 0, 0); drive_a(8'h02, 0, 0); drive_a(8'h03, 0, 0); drive_a(8'h04, 0, 1); idle_a();
        check_pkt(16'h0002, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
        chk("short_line_idx", a_line_idx, 16'd3);

        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("rst2_err", 16'(a_err), 16'd0);
        chk("rst2_line_idx", a_line_idx, 16'd0);
        rst = 1'b0;
        q.delete();

        // Long line: closes after four bytes, leftover bytes open the next packet.
        drive_a(8'h01, 1, 0); drive_a(8'h02, 0, 0); drive_a(8'h03, 0, 0); drive_a(8'h04, 0, 0);
        drive_a(8'h05, 0, 0); drive_a(8'h06, 0, 0); drive_a(8'h07, 0, 0); drive_a(8'h08, 0, 1); idle_a();
        check_pkt(16'h0000, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
        check_pkt(16'h0001, 8'h05, 8'h06, 8'h07, 8'h08, 8'h1A);
        chk("long_err", 16'(a_err), 16'd1);

        // Reset while a payload start pulse is on the wire.
        drive_a(8'h01, 1, 0); drive_a(8'h02, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_tx_start", 16'(a_tx_start), 16'd0);
        chk("midrst_in_ready", 16'(a_in_ready), 16'd0);
        chk("midrst_tx_data",  16'(a_tx_data),  16'd0);
        chk("midrst_line_idx", a_line_idx,      16'd0);
        chk("midrst_err",      16'(a_err),      16'd0);
        @(negedge clk);
        a_in_valid = 1'b0; a_in_sof = 1'b0; a_in_eol = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        drive_a(8'h01, 0, 0); drive_a(8'h02, 0, 0); drive_a(8'h03, 0, 0); drive_a(8'h04, 0, 1); idle_a();
        check_pkt(16'h0000, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);

        // Instance b: spacing GUARD+1 = 5, stable tx_data, no consumption without in_ready.
        exp_b = '{8'hAA, 8'h55, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        cyc = 0; last_cyc = 0; npulse = 0; bidx = 0; stab_err = 0; last_data = 8'h00;
        while (npulse < 9 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (b_tx_start) begin
                if (npulse > 0) chk($sformatf("b_gap%0d", npulse), 16'(cyc - last_cyc), 16'd5);
                chk($sformatf("b_byte%0d", npulse), {8'h00, b_tx_data}, {8'h00, exp_b[npulse]});
                last_cyc = cyc;
                last_data = b_tx_data;
                npulse++;
            end else if (npulse > 0 && b_tx_data !== last_data) begin
                stab_err++;
            end
            b_in_valid = (bidx < 4);
            b_in_data  = 8'(bidx + 1);
            b_in_sof   = (bidx == 0);
            b_in_eol   = (bidx == 3);
            if (b_in_valid && b_in_ready) bidx++;
        end
        chk("b_pulses", 16'(npulse), 16'd9);
        chk("b_stable", 16'(stab_err), 16'd0);
        chk("b_consumed", 16'(bidx), 16'd4);
        chk("b_err", 16'(b_err), 16'd0);
        chk("b_line_idx", b_line_idx, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
